// File: rtl/addepreamble_if.sv
// Byte-stream bundle between the CRC appender, the preamble stage and the MII/RMII nibbler.
// Signal names match the original flat ports so existing hookups map one-to-one.
interface addepreamble_if;
   logic       i_en;
   logic       i_v;
   logic [7:0] i_d;
   logic       o_v;
   logic [7:0] o_d;
   logic       o_busy;
   logic       o_err;

   modport master (
      output i_en, i_v, i_d,
      input  o_v, o_d, o_busy, o_err
   );

   modport slave (
      input  i_en, i_v, i_d,
      output o_v, o_d, o_busy, o_err
   );
endinterface

// File: rtl/addepreamble.sv
// Prefixes each Tx frame with 7x 0x55 + SFD 0xd5 and enforces a minimum inter-packet gap.
// Upstream cannot stall, so frame bytes ride an 8-deep delay line while the preamble is sent.
module addepreamble #(
   parameter int IPG   = 12,
   parameter int LGIPG = 4
) (
   input  logic          i_clk,
   input  logic          i_areset_n,
   addepreamble_if.slave bus
);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, BYP, GAP} state_t;

   state_t           state, state_nxt;
   logic [LGIPG-1:0] cnt, cnt_nxt;
   logic [2:0]       pcnt, pcnt_nxt;

   logic       lastv, drop;
   logic [7:0] dl_v;
   logic [7:0] dl_d [8];

   logic       start, accept, shift, s0_v;
   logic       v_nxt;
   logic [7:0] d_nxt;

   logic       v_q, busy_q, err_q;
   logic [7:0] d_q;

   assign start  = bus.i_v && !lastv;
   assign accept = start && (state == IDLE);
   assign shift  = (state != IDLE) || accept;
   // Bytes of a frame that was refused, or of a new frame arriving mid-frame, never enter the line.
   assign s0_v   = bus.i_v && !drop && (accept || ((state != IDLE) && !start));

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         state <= IDLE;
         cnt   <= '0;
         pcnt  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         pcnt  <= pcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pcnt_nxt  = pcnt;
      v_nxt     = 1'b0;
      d_nxt     = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               v_nxt = 1'b1;
               if (bus.i_en) begin
                  state_nxt = PRE;
                  pcnt_nxt  = '0;
                  d_nxt     = 8'h55;
               end else begin
                  state_nxt = BYP;
                  d_nxt     = bus.i_d;
               end
            end
         end
         PRE: begin
            v_nxt = 1'b1;
            d_nxt = 8'h55;
            // First preamble byte left on the accept edge; six more follow from here.
            if (pcnt == 3'd5) state_nxt = SFD;
            else              pcnt_nxt  = pcnt + 3'd1;
         end
         SFD: begin
            v_nxt     = 1'b1;
            d_nxt     = 8'hd5;
            state_nxt = DATA;
         end
         DATA: begin
            v_nxt = dl_v[7];
            d_nxt = dl_v[7] ? dl_d[7] : 8'h00;
            if (!dl_v[7]) begin
               state_nxt = GAP;
               cnt_nxt   = '0;
            end
         end
         BYP: begin
            v_nxt = bus.i_v;
            d_nxt = bus.i_v ? bus.i_d : 8'h00;
            if (!bus.i_v) begin
               state_nxt = GAP;
               cnt_nxt   = '0;
            end
         end
         GAP: begin
            if (cnt == LGIPG'(IPG - 1)) state_nxt = IDLE;
            else                        cnt_nxt   = cnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         dl_v <= '0;
         for (int unsigned k = 0; k < 8; k++) dl_d[k] <= '0;
      end else if (shift) begin
         dl_v    <= {dl_v[6:0], s0_v};
         dl_d[0] <= bus.i_d;
         for (int unsigned k = 1; k < 8; k++) dl_d[k] <= dl_d[k-1];
      end
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         lastv  <= 1'b0;
         drop   <= 1'b0;
         v_q    <= 1'b0;
         d_q    <= '0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         lastv  <= bus.i_v;
         v_q    <= v_nxt;
         d_q    <= d_nxt;
         busy_q <= (state_nxt != IDLE);
         err_q  <= start && (state != IDLE);
         // A refused frame stays refused until its valid run ends, even if the block goes idle.
         if (start && (state != IDLE)) drop <= 1'b1;
         else if (!bus.i_v)            drop <= 1'b0;
      end
   end

   assign bus.o_v    = v_q;
   assign bus.o_d    = d_q;
   assign bus.o_busy = busy_q;
   assign bus.o_err  = err_q;

endmodule

// File: tb/tb_addepreamble.sv
// Bench for addepreamble: per-segment stimulus traces, a frame-level reference model and
// cycle-by-cycle comparison of o_v/o_d/o_busy/o_err.
module tb_addepreamble;

   localparam int IPG  = 12;
   localparam int MAXC = 400;

   logic clk;
   logic rst_n;

   addepreamble_if bus ();

   addepreamble #(.IPG(IPG), .LGIPG(4)) dut (
      .i_clk      (clk),
      .i_areset_n (rst_n),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Stimulus trace and expected outputs, indexed by cycle since reset release.
   bit         tv [MAXC];
   logic [7:0] td [MAXC];
   bit         ten[MAXC];
   bit         ev [MAXC];
   logic [7:0] ed [MAXC];
   bit         eb [MAXC];
   bit         ee [MAXC];
   bit         ov_log[MAXC];
   bit         oe_log[MAXC];

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic clear_trace();
      for (int c = 0; c < MAXC; c++) begin
         tv[c]  = 1'b0;
         td[c]  = 8'($urandom);
         ten[c] = 1'($urandom);
      end
   endtask

   task automatic add_frame(input int s, input int len, input bit en);
      for (int k = 0; k < len; k++) if (s + k < MAXC) tv[s+k] = 1'b1;
      ten[s] = en;
   endtask

   task automatic put(input int i, input logic [7:0] d);
      if (i < MAXC) begin
         ev[i] = 1'b1;
         ed[i] = d;
      end
   endtask

   // Frame-level model: a frame is accepted only if it starts once the previous one's
   // gap has fully elapsed; otherwise it is dropped whole with an error pulse.
   task automatic build_expected(input int n);
      int free_at = 0;
      bit prev    = 1'b0;
      for (int c = 0; c < MAXC; c++) begin
         ev[c] = 0; ed[c] = 0; eb[c] = 0; ee[c] = 0;
      end
      for (int c = 0; c < n; c++) begin
         if (tv[c] && !prev) begin
            int len = 0;
            int last;
            while (c + len < n && tv[c+len]) len++;
            if (c >= free_at) begin
               if (ten[c]) begin
                  for (int k = 1; k <= 7; k++) put(c + k, 8'h55);
                  put(c + 8, 8'hd5);
                  for (int k = 0; k < len; k++) put(c + 9 + k, td[c+k]);
                  last = c + 8 + len;
               end else begin
                  for (int k = 0; k < len; k++) put(c + 1 + k, td[c+k]);
                  last = c + len;
               end
               for (int b = c + 1; b <= last + IPG; b++) if (b < MAXC) eb[b] = 1'b1;
               free_at = last + IPG + 1;
            end else if (c + 1 < MAXC) begin
               ee[c+1] = 1'b1;
            end
         end
         prev = tv[c];
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      bus.i_v  = 1'b0;
      bus.i_d  = 8'h00;
      bus.i_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_segment(input int n, input int seg);
      for (int c = 0; c < n; c++) begin
         chk($sformatf("seg%0d c%0d o_v", seg, c),    bus.o_v,    ev[c]);
         chk($sformatf("seg%0d c%0d o_d", seg, c),    bus.o_d,    ed[c]);
         chk($sformatf("seg%0d c%0d o_busy", seg, c), bus.o_busy, eb[c]);
         chk($sformatf("seg%0d c%0d o_err", seg, c),  bus.o_err,  ee[c]);
         ov_log[c] = bus.o_v;
         oe_log[c] = bus.o_err;
         bus.i_v  = tv[c];
         bus.i_d  = td[c];
         bus.i_en = ten[c];
         @(posedge clk);
         #1;
      end
      bus.i_v = 1'b0;
   endtask

   initial begin
      int errs;
      int first_end;
      int next_start;

      rst_n    = 1'b0;
      bus.i_v  = 1'b0;
      bus.i_d  = 8'h00;
      bus.i_en = 1'b0;
      #3;
      chk("reset o_v", bus.o_v, 0);
      chk("reset o_d", bus.o_d, 0);
      chk("reset o_busy", bus.o_busy, 0);
      chk("reset o_err", bus.o_err, 0);

      // Preamble + 4 data bytes.
      do_reset(); clear_trace();
      add_frame(2, 4, 1'b1);
      td[2] = 8'h01; td[3] = 8'h02; td[4] = 8'h03; td[5] = 8'h04;
      build_expected(60); run_segment(60, 1);

      // Bypass.
      do_reset(); clear_trace();
      add_frame(2, 3, 1'b0);
      td[2] = 8'ha1; td[3] = 8'ha2; td[4] = 8'ha3;
      build_expected(40); run_segment(40, 2);

      // Frame starting inside the gap is dropped, the following one is sent.
      do_reset(); clear_trace();
      add_frame(2, 4, 1'b1);
      add_frame(19, 3, 1'b1);
      add_frame(30, 2, 1'b1);
      build_expected(80); run_segment(80, 3);
      errs = 0;
      for (int c = 0; c < 80; c++) errs += int'(oe_log[c]);
      chk("drop err pulses", errs, 1);

      // Refused frame that is still valid when the block returns to idle stays dropped.
      do_reset(); clear_trace();
      add_frame(2, 4, 1'b0);
      add_frame(15, 10, 1'b1);
      add_frame(30, 2, 1'b0);
      build_expected(60); run_segment(60, 4);

      // Start on the first cycle o_busy is low: accepted.
      do_reset(); clear_trace();
      add_frame(2, 3, 1'b1);
      add_frame(26, 2, 1'b0);
      build_expected(60); run_segment(60, 5);
      first_end = 0; next_start = 0;
      for (int c = 0; c < 59; c++)
         if (first_end == 0 && ov_log[c] && !ov_log[c+1]) first_end = c;
      for (int c = 0; c < 60; c++)
         if (next_start == 0 && c > first_end && first_end != 0 && ov_log[c]) next_start = c;
      chk("ipg idle cycles", next_start - first_end - 1, IPG + 1);

      // Async reset during the third preamble byte, then a clean frame.
      do_reset(); clear_trace();
      add_frame(2, 6, 1'b1);
      build_expected(5); run_segment(5, 6);
      bus.i_v = 1'b1;
      chk("pre-reset o_v", bus.o_v, 1);
      chk("pre-reset o_d", bus.o_d, 8'h55);
      #2;
      rst_n   = 1'b0;
      bus.i_v = 1'b0;
      #1;
      chk("async reset o_v", bus.o_v, 0);
      chk("async reset o_d", bus.o_d, 0);
      chk("async reset o_busy", bus.o_busy, 0);
      chk("async reset o_err", bus.o_err, 0);
      do_reset(); clear_trace();
      add_frame(1, 2, 1'b1);
      build_expected(40); run_segment(40, 7);

      // Single-byte frame with i_en toggling after the start.
      do_reset(); clear_trace();
      add_frame(3, 1, 1'b1);
      td[3] = 8'hff;
      for (int c = 4; c < 30; c++) ten[c] = 1'(c % 2);
      build_expected(40); run_segment(40, 8);

      // Randomized frame streams with random gaps, lengths and enables.
      for (int seg = 0; seg < 8; seg++) begin
         int t;
         do_reset(); clear_trace();
         t = int'($urandom_range(0, 3)) + 1;
         while (t < 250) begin
            int len = int'($urandom_range(1, 20));
            add_frame(t, len, 1'($urandom));
            t += len + int'($urandom_range(1, 30));
         end
         build_expected(300); run_segment(300, 10 + seg);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
